// File: rtl/register_file_nr_mw_ff_pkg.sv
// Shared helpers for the multi-port flip-flop register file.
package register_file_pkg;

    // Widest word the byte-mask helper can expand; wider words are not supported.
    localparam int MAX_DATA_WIDTH = 1024;
    localparam int MAX_BYTES      = MAX_DATA_WIDTH / 8;

    // Number of byte lanes in a word.
    function automatic int num_bytes(input int data_width);
        return data_width / 8;
    endfunction

    // Expands one enable bit per byte into a per-bit mask.
    function automatic logic [MAX_DATA_WIDTH-1:0] be_to_mask(input logic [MAX_BYTES-1:0] be);
        logic [MAX_DATA_WIDTH-1:0] mask;
        mask = '0;
        for (int b = 0; b < MAX_BYTES; b++) begin
            mask[b*8 +: 8] = {8{be[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/register_file_nr_mw_ff_if.sv
// Bus bundle for the multi-port register file: clear, read ports and write ports.
interface register_file_nr_mw_ff_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RPORTS = 2,
    parameter int NUM_WPORTS = 2
);
    import register_file_pkg::*;

    localparam int NB = num_bytes(DATA_WIDTH);

    logic                                  Clear;
    logic [NUM_RPORTS-1:0]                 ReadEnable;
    logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0] ReadAddr;
    logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0] ReadData;
    logic [NUM_WPORTS-1:0]                 WriteEnable;
    logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0] WriteAddr;
    logic [NUM_WPORTS-1:0][NB-1:0]         WriteBE;
    logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0] WriteData;

    modport master (
        output Clear, ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteBE, WriteData,
        input  ReadData
    );

    modport slave (
        input  Clear, ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteBE, WriteData,
        output ReadData
    );

endinterface

// File: rtl/register_file_nr_mw_ff_wport_arbiter.sv
// Per-word write arbiter: decides, byte by byte, whether any write port hits
// this word and which port's data lands. The highest-indexed port wins a byte.
module register_file_wport_arbiter
    import register_file_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WPORTS = 2,
    localparam int NB        = num_bytes(DATA_WIDTH)
) (
    input  logic [NUM_WPORTS-1:0]                 write_enable,
    input  logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0] write_addr,
    input  logic [NUM_WPORTS-1:0][NB-1:0]         write_be,
    input  logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0]                 word_idx,
    output logic [NB-1:0]                         byte_we,
    output logic [DATA_WIDTH-1:0]                 byte_wdata
);

    // Ascending scan so later (higher-indexed) ports overwrite earlier winners.
    always_comb begin
        byte_we    = '0;
        byte_wdata = '0;
        for (int p = 0; p < NUM_WPORTS; p++) begin
            for (int b = 0; b < NB; b++) begin
                if (write_enable[p] && (write_addr[p] == word_idx) && write_be[p][b]) begin
                    byte_we[b]            = 1'b1;
                    byte_wdata[b*8 +: 8]  = write_data[p][b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/register_file_nr_mw_ff.sv
// Multi-read, multi-write flip-flop register file with byte enables,
// non-power-of-two depth and a synchronous whole-array clear.
module register_file_nr_mw_ff
    import register_file_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 2**ADDR_WIDTH,
    parameter int NUM_RPORTS = 2,
    parameter int NUM_WPORTS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    register_file_nr_mw_ff_if.slave  bus
);

    localparam int NB = num_bytes(DATA_WIDTH);

    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]  words;
    logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0] raddr_q;

    // Only indices below NUM_WORDS get storage, so out-of-range writes match
    // no arbiter and cannot alias onto an implemented word.
    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
        logic [NB-1:0]         byte_we;
        logic [DATA_WIDTH-1:0] byte_wdata;
        logic [DATA_WIDTH-1:0] bit_mask;
        logic [DATA_WIDTH-1:0] word_q;

        register_file_wport_arbiter #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_WPORTS (NUM_WPORTS)
        ) u_arb (
            .write_enable (bus.WriteEnable),
            .write_addr   (bus.WriteAddr),
            .write_be     (bus.WriteBE),
            .write_data   (bus.WriteData),
            .word_idx     (ADDR_WIDTH'(k)),
            .byte_we      (byte_we),
            .byte_wdata   (byte_wdata)
        );

        assign bit_mask = DATA_WIDTH'(be_to_mask(MAX_BYTES'(byte_we)));

        // Word storage: clear beats every write; unselected bytes hold.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else if (bus.Clear) begin
                word_q <= '0;
            end else begin
                word_q <= (word_q & ~bit_mask) | (byte_wdata & bit_mask);
            end
        end

        assign words[k] = word_q;
    end

    // Read-address capture; the registers survive Clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr_q <= '0;
        end else begin
            for (int r = 0; r < NUM_RPORTS; r++) begin
                if (bus.ReadEnable[r]) begin
                    raddr_q[r] <= bus.ReadAddr[r];
                end
            end
        end
    end

    // Read muxes: an address with no implemented word reads as zero.
    always_comb begin
        bus.ReadData = '0;
        for (int r = 0; r < NUM_RPORTS; r++) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (raddr_q[r] == ADDR_WIDTH'(k)) begin
                    bus.ReadData[r] = words[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_register_file_nr_mw_ff.sv
// Self-checking bench for register_file_nr_mw_ff (20 words, 2R/2W, 32-bit).
module tb_register_file_nr_mw_ff;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int NW  = 20;
    localparam int NR  = 2;
    localparam int NWP = 2;
    localparam int NB  = DW / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    register_file_nr_mw_ff_if #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_RPORTS (NR),
        .NUM_WPORTS (NWP)
    ) bus ();

    register_file_nr_mw_ff #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_WORDS  (NW),
        .NUM_RPORTS (NR),
        .NUM_WPORTS (NWP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: plain word array plus the captured read addresses.
    logic [DW-1:0] m_mem   [NW];
    int            m_raddr [NR];

    function automatic logic [DW-1:0] m_read(input int a);
        if (a < NW) return m_mem[a];
        return '0;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: reset clears everything, clear wipes words, otherwise
    // ports are applied in index order so the highest port owns each byte.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) m_mem[i] = '0;
            for (int r = 0; r < NR; r++) m_raddr[r] = 0;
        end else begin
            if (bus.Clear) begin
                for (int i = 0; i < NW; i++) m_mem[i] = '0;
            end else begin
                for (int p = 0; p < NWP; p++) begin
                    if (bus.WriteEnable[p] && int'(bus.WriteAddr[p]) < NW) begin
                        for (int b = 0; b < NB; b++) begin
                            if (bus.WriteBE[p][b])
                                m_mem[int'(bus.WriteAddr[p])][8*b +: 8] = bus.WriteData[p][8*b +: 8];
                        end
                    end
                end
            end
            for (int r = 0; r < NR; r++) begin
                if (bus.ReadEnable[r]) m_raddr[r] = int'(bus.ReadAddr[r]);
            end
        end
    end

    // Every-cycle comparison of all read ports against the model.
    always @(negedge clk) begin
        for (int r = 0; r < NR; r++) begin
            check($sformatf("cycle_rd%0d", r), bus.ReadData[r], m_read(m_raddr[r]));
        end
    end

    task automatic idle();
        bus.Clear       = 1'b0;
        bus.ReadEnable  = '0;
        bus.ReadAddr    = '0;
        bus.WriteEnable = '0;
        bus.WriteAddr   = '0;
        bus.WriteBE     = '0;
        bus.WriteData   = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input int p, input int addr, input logic [DW-1:0] data, input logic [NB-1:0] be);
        bus.WriteEnable[p] = 1'b1;
        bus.WriteAddr[p]   = AW'(addr);
        bus.WriteData[p]   = data;
        bus.WriteBE[p]     = be;
    endtask

    task automatic rd(input int r, input int addr);
        bus.ReadEnable[r] = 1'b1;
        bus.ReadAddr[r]   = AW'(addr);
    endtask

    task automatic randomize_inputs();
        bus.Clear       = ($urandom_range(0, 31) == 0);
        bus.ReadEnable  = NR'($urandom_range(0, 3));
        bus.ReadAddr    = (NR*AW)'($urandom_range(0, 1023));
        bus.WriteEnable = NWP'($urandom_range(0, 3));
        bus.WriteAddr   = (NWP*AW)'($urandom_range(0, 1023));
        bus.WriteBE     = (NWP*NB)'($urandom_range(0, 255));
        bus.WriteData   = {$urandom, $urandom};
    endtask

    initial begin
        idle();
        #1 rst_n = 1'b0;
        repeat (4) begin
            randomize_inputs();
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        idle();

        // Reset state seen through both read ports.
        rd(0, 0); rd(1, 3); tick();
        check("rst_rd0", bus.ReadData[0], 32'h0);
        check("rst_rd1", bus.ReadData[1], 32'h0);

        // Asynchronous reset between edges; the pending write must be lost.
        wr(0, 3, 32'h1122_3344, 4'hF); tick();
        check("pre_async_rd1", bus.ReadData[1], 32'h1122_3344);
        wr(0, 3, 32'hFFFF_FFFF, 4'hF);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_rd1", bus.ReadData[1], 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
        rd(1, 3); tick();
        check("write_lost_in_reset", bus.ReadData[1], 32'h0);

        // Basic write, read, and tracking of a held address.
        wr(0, 7, 32'hDEAD_BEEF, 4'hF); tick();
        rd(1, 7); tick();
        check("basic_rd", bus.ReadData[1], 32'hDEAD_BEEF);
        wr(0, 7, 32'h1234_5678, 4'hF); tick();
        check("track_held_addr", bus.ReadData[1], 32'h1234_5678);

        // Byte merge with port 1 winning the low half.
        wr(0, 4, 32'h0, 4'hF); tick();
        wr(0, 4, 32'hAAAA_AAAA, 4'hF); wr(1, 4, 32'h5555_5555, 4'h3); tick();
        rd(0, 4); tick();
        check("byte_priority_merge", bus.ReadData[0], 32'hAAAA_5555);

        // Partial byte enable and zero byte enable.
        wr(1, 4, 32'h00EE_0000, 4'h4); wr(0, 4, 32'hFFFF_FFFF, 4'h0); tick();
        check("partial_be", bus.ReadData[0], 32'hAAEE_5555);

        // Depth boundary: out-of-range write and read, last word.
        wr(0, 25, 32'hFFFF_FFFF, 4'hF); tick();
        rd(0, 5); rd(1, 9); tick();
        check("oob_no_alias5", bus.ReadData[0], 32'h0);
        check("oob_no_alias9", bus.ReadData[1], 32'h0);
        rd(0, 25); tick();
        check("oob_read", bus.ReadData[0], 32'h0);
        wr(1, 19, 32'h1919_1919, 4'hF); tick();
        rd(1, 19); tick();
        check("last_word", bus.ReadData[1], 32'h1919_1919);

        // Write and address capture on the same edge.
        wr(0, 9, 32'h0000_CAFE, 4'hF); rd(0, 9); tick();
        check("same_edge_rw", bus.ReadData[0], 32'h0000_CAFE);

        // Fill, then clear with a competing write; addresses must survive.
        for (int k = 0; k < NW; k++) begin
            wr(0, k, 32'h0101_0101 * DW'(k + 1), 4'hF); tick();
        end
        rd(1, 2); rd(0, 19); tick();
        check("pre_clear_rd1", bus.ReadData[1], 32'h0303_0303);
        check("pre_clear_rd0", bus.ReadData[0], 32'h1414_1414);
        bus.Clear = 1'b1; wr(0, 2, 32'h1, 4'hF); tick();
        check("clear_rd1", bus.ReadData[1], 32'h0);
        check("clear_rd0", bus.ReadData[0], 32'h0);
        wr(0, 2, 32'h77, 4'hF); tick();
        check("clear_keeps_raddr", bus.ReadData[1], 32'h77);
        for (int k = 0; k < NW; k++) begin
            rd(0, k); tick();
        end

        // Random traffic with one mid-cycle asynchronous reset pulse.
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            if (i == 1500) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_file_nr_mw_ff.md
Name: register_file_nr_mw_ff

Overview:
- Parametrised flip-flop register file with NUM_RPORTS read ports and NUM_WPORTS write ports.
- Supports non-power-of-two depth, per-byte write enables and a fixed write-conflict priority.
- Provides a synchronous whole-array clear.
- Drop-in storage for multi-issue cores and accelerator operand buffers; generalises the single-read/single-write FF register file.

Parameters:
- ADDR_WIDTH, 5, address bits per port.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- NUM_WORDS, 2**ADDR_WIDTH, implemented words; 1 <= NUM_WORDS <= 2**ADDR_WIDTH.
- NUM_RPORTS, 2, number of read ports, >= 1.
- NUM_WPORTS, 2, number of write ports, >= 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- Clear  in  1  synchronous clear of all words.
- ReadEnable  in  NUM_RPORTS  per-port read-address capture enable.
- ReadAddr  in  NUM_RPORTS x ADDR_WIDTH  read addresses.
- ReadData  out  NUM_RPORTS x DATA_WIDTH  read data.
- WriteEnable  in  NUM_WPORTS  per-port write request.
- WriteAddr  in  NUM_WPORTS x ADDR_WIDTH  write addresses.
- WriteBE  in  NUM_WPORTS x DATA_WIDTH/8  byte enables.
- WriteData  in  NUM_WPORTS x DATA_WIDTH  write data.

Behaviour:
- Reset (rst_n low, asynchronous): all words and all read-address registers become 0, so every ReadData = 0 from reset assertion.
- Read, per port r:
  - Rising edge with ReadEnable[r]=1: RAddrReg[r] <= ReadAddr[r].
  - ReadEnable[r]=0: RAddrReg[r] holds.
  - ReadData[r] is combinational from RAddrReg[r] and current array content. Latency is 1 cycle from address capture.
  - ReadData[r] tracks later writes to the held address one cycle after the write edge.
  - RAddrReg[r] >= NUM_WORDS: ReadData[r] = 0.
- Write, per byte b of word k:
  - Updated at the rising edge when some port p has WriteEnable[p]=1, WriteAddr[p]==k and WriteBE[p][b]=1.
  - Byte gets WriteData[p][8b+7:8b]. Bytes without an enabled write hold.
- Conflicts: several ports hitting the same byte of the same word → highest-indexed port wins. Resolution is per byte, so ports with disjoint BE to one word merge.
- Write to address >= NUM_WORDS: ignored; no side effect, no aliasing.
- Write enabled with WriteBE=0: no change.
- Read/write same address, same cycle:
  - The captured address reflects the new data on ReadData after that edge (write and capture land on the same edge).
  - No old-data read mode exists.
- Clear=1 at a rising edge: every word becomes 0. Clear has priority over all writes in that cycle. Read-address registers are unaffected.
- Reset asserted mid-operation: the array and address registers clear immediately. Writes presented in that cycle are lost.
- No X propagation: an unwritten word reads 0.
- Write-enable decode and priority resolution are purely combinational. The only state is the array and the NUM_RPORTS address registers.

Decomposition:
- Package register_file_pkg holds:
  - function be_to_mask(be) expanding byte enables to a bit mask;
  - localparam-style helper NUM_BYTES(DATA_WIDTH)=DATA_WIDTH/8.
- One sub-module, register_file_wport_arbiter:
  - inputs: all write ports and a word index;
  - outputs: per-byte write enable and per-byte winning data for that word;
  - instantiated once per word in a generate loop.
- Read muxes stay inline.

Test Plan:
- Reset: hold rst_n low with random inputs, release, ReadEnable all=1, ReadAddr={3,0} → ReadData={0,0}. Then assert rst_n low asynchronously between edges → ReadData drops to 0 immediately.
- Basic R/W: port0 writes 0xDEADBEEF to addr 7, BE=0xF, then port1 reads 7 → ReadData[1]=0xDEADBEEF one cycle after capture. ReadEnable[1]=0 next cycle while addr 7 is rewritten with 0x12345678 → ReadData[1] becomes 0x12345678 after the write edge.
- Byte merge and priority: addr 4=0, then port0 (0xAAAAAAAA, BE=0xF) and port1 (0x55555555, BE=0x3) in the same cycle → word 4=0xAAAA5555.
- Depth boundary, NUM_WORDS=20, ADDR_WIDTH=5:
  - Write 0xFFFFFFFF to addr 25 → no word changes.
  - Read addr 25 → 0.
  - Write/read addr 19 → works.
- Clear: fill words 0..19 with nonzero values, then assert Clear together with a port0 write of 0x1 to addr 2 → all words read 0, including word 2. Previously captured read addresses are retained.
- Same-edge read/write: port0 writes 0xCAFE to addr 9 while port0 read captures addr 9 → ReadData[0]=0xCAFE in the following cycle.
